// File: rtl/nios_system_info_regs_pkg.sv
// Package: nios_sysinfo_pkg
// Shared constants for the system-info slave: the word-address map, the
// INFO version field, the core-count ceiling, and a helper that builds the
// INFO word.
package nios_sysinfo_pkg;

  localparam logic [2:0] ADDR_ID      = 3'd0;
  localparam logic [2:0] ADDR_TSTAMP  = 3'd1;
  localparam logic [2:0] ADDR_INFO    = 3'd2;
  localparam logic [2:0] ADDR_UP_LO   = 3'd3;
  localparam logic [2:0] ADDR_UP_HI   = 3'd4;
  localparam logic [2:0] ADDR_BARRIER = 3'd5;
  localparam logic [2:0] ADDR_SCRATCH = 3'd6;

  localparam logic [15:0] INFO_VERSION = 16'h0001;
  localparam int unsigned MAX_CORES    = 16;

  // INFO word: {version, 11'd0, core count in 5 bits}
  function automatic logic [31:0] info_word(input int unsigned num_cores);
    info_word = {INFO_VERSION, 11'd0, 5'(num_cores)};
  endfunction

endpackage

// File: rtl/nios_system_info_regs_if.sv
// Interface: nios_system_info_regs_if
// Avalon-MM control_slave signals for the system-info block.
//   address   [2:0]  word address
//   read             one-cycle read strobe
//   write            one-cycle write strobe
//   writedata [31:0] write data
//   readdata  [31:0] registered read data (slave -> master)
interface nios_system_info_regs_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, output read, output write, output writedata,
                  input  readdata);
  modport slave  (input  address, input  read, input  write, input  writedata,
                  output readdata);
endinterface

// File: rtl/nios_barrier_sync.sv
// Module: nios_barrier_sync
// Hardware barrier for NUM_CORES participants. Each core sets its arrive bit
// (write-1-to-set). When all bits are set, the next edge clears the mask,
// bumps the generation counter and pulses o_release for one cycle.
//   clock, reset_n  clock / async active-low reset
//   i_wr            BARRIER write this cycle
//   i_wdata         arrive bits to set
//   o_arrive        registered arrive mask
//   o_gen           generation counter (wraps modulo 2^GEN_W)
//   o_release       one-cycle release pulse
module nios_barrier_sync #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned GEN_W     = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 i_wr,
  input  logic [NUM_CORES-1:0] i_wdata,
  output logic [NUM_CORES-1:0] o_arrive,
  output logic [GEN_W-1:0]     o_gen,
  output logic                 o_release
);

  logic [NUM_CORES-1:0] r_arrive;
  logic [GEN_W-1:0]     r_gen;
  logic                 r_release;
  logic                 w_all_in;

  assign w_all_in = (r_arrive == '1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_arrive  <= '0;
      r_gen     <= '0;
      r_release <= 1'b0;
    end else if (w_all_in) begin
      // A write landing in the release cycle seeds the next round.
      r_arrive  <= i_wr ? i_wdata : '0;
      r_gen     <= r_gen + 1'b1;
      r_release <= 1'b1;
    end else begin
      if (i_wr) r_arrive <= r_arrive | i_wdata;
      r_release <= 1'b0;
    end
  end

  assign o_arrive  = r_arrive;
  assign o_gen     = r_gen;
  assign o_release = r_release;

endmodule

// File: rtl/nios_system_info_regs.sv
// Module: nios_system_info_regs
// System-identification and coordination slave: ID, build timestamp, INFO,
// 64-bit uptime with atomic LO-then-HI read, a hardware barrier and a
// scratch register. Read latency is one cycle; readdata holds between reads.
//   clock            system clock
//   reset_n          async active-low reset
//   avs              Avalon-MM control_slave (slave modport)
//   barrier_release  one-cycle pulse when all cores have arrived
module nios_system_info_regs
  import nios_sysinfo_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned GEN_W     = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  nios_system_info_regs_if.slave  avs,
  output logic                    barrier_release
);

  logic [63:0]          r_uptime;
  logic [31:0]          r_hi_shadow;
  logic [31:0]          r_scratch;
  logic [31:0]          r_readdata;
  logic [31:0]          w_rd_data;
  logic                 w_rd_en;
  logic                 w_bar_wr;
  logic [NUM_CORES-1:0] w_arrive;
  logic [GEN_W-1:0]     w_gen;

  // Write wins if the fabric ever asserts both strobes.
  assign w_rd_en  = avs.read && !avs.write;
  assign w_bar_wr = avs.write && (avs.address == ADDR_BARRIER);

  nios_barrier_sync #(
    .NUM_CORES (NUM_CORES),
    .GEN_W     (GEN_W)
  ) u_barrier (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_wr      (w_bar_wr),
    .i_wdata   (avs.writedata[NUM_CORES-1:0]),
    .o_arrive  (w_arrive),
    .o_gen     (w_gen),
    .o_release (barrier_release)
  );

  always_comb begin
    w_rd_data = '0;
    case (avs.address)
      ADDR_ID:      w_rd_data = SYSTEM_ID;
      ADDR_TSTAMP:  w_rd_data = TIMESTAMP;
      ADDR_INFO:    w_rd_data = info_word(NUM_CORES);
      ADDR_UP_LO:   w_rd_data = r_uptime[31:0];
      ADDR_UP_HI:   w_rd_data = r_hi_shadow;
      ADDR_BARRIER: begin
        w_rd_data[NUM_CORES-1:0] = w_arrive;
        w_rd_data[16 +: GEN_W]   = w_gen;
      end
      ADDR_SCRATCH: w_rd_data = r_scratch;
      default:      w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_uptime    <= '0;
      r_hi_shadow <= '0;
      r_scratch   <= '0;
      r_readdata  <= '0;
    end else begin
      r_uptime <= r_uptime + 64'd1;
      if (w_rd_en) begin
        r_readdata <= w_rd_data;
        // Same-cycle sample of the upper half keeps the 64-bit read atomic.
        if (avs.address == ADDR_UP_LO) r_hi_shadow <= r_uptime[63:32];
      end
      if (avs.write && (avs.address == ADDR_SCRATCH)) r_scratch <= avs.writedata;
    end
  end

  assign avs.readdata = r_readdata;

endmodule

// File: tb/tb_nios_system_info_regs.sv
module tb_nios_system_info_regs;

  localparam logic [31:0] SYS_ID = 32'h5BA1_2C74;
  localparam logic [31:0] TSTAMP = 32'h2024_0611;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic barrier_release;
  int   checks   = 0;
  int   failures = 0;
  int   cyc;
  logic [31:0] d;

  nios_system_info_regs_if bus ();

  nios_system_info_regs #(
    .SYSTEM_ID (SYS_ID),
    .TIMESTAMP (TSTAMP),
    .NUM_CORES (4),
    .GEN_W     (2)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .avs             (bus),
    .barrier_release (barrier_release)
  );

  always #5 clock = ~clock;

  // Reference cycle count since reset release (expected uptime).
  always @(posedge clock or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] data);
    @(negedge clock);
    bus.address = a;
    bus.read    = 1'b1;
    @(negedge clock);
    bus.read = 1'b0;
    data = bus.readdata;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] data);
    @(negedge clock);
    bus.address   = a;
    bus.writedata = data;
    bus.write     = 1'b1;
    @(negedge clock);
    bus.write = 1'b0;
  endtask

  initial begin
    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;

    // 1: reset and identification words
    #23;
    chk("reset_readdata", bus.readdata, 32'h0);
    chk("reset_release", {31'd0, barrier_release}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    rd(3'd0, d); chk("id", d, SYS_ID);
    rd(3'd1, d); chk("tstamp", d, TSTAMP);
    rd(3'd2, d); chk("info", d, 32'h0001_0004);
    @(negedge clock);
    chk("readdata_hold", bus.readdata, 32'h0001_0004);
    wr(3'd0, 32'h0);
    rd(3'd0, d); chk("id_ro", d, SYS_ID);

    // 2: uptime, LO sampled by the edge where cyc reaches 100
    for (int i = 0; i < 300 && cyc != 99; i++) @(negedge clock);
    chk("wait_cyc99", cyc, 32'd99);
    rd(3'd3, d); chk("up_lo_100", d, 32'd100);
    repeat (50) @(negedge clock);
    rd(3'd4, d); chk("up_hi_0", d, 32'h0);
    force dut.r_uptime = 64'h0000_0000_FFFF_FFFE;
    rd(3'd3, d); chk("up_lo_forced", d, 32'hFFFF_FFFE);
    rd(3'd4, d); chk("up_hi_forced", d, 32'h0);
    force dut.r_uptime = 64'h1234_5678_0000_0010;
    rd(3'd3, d); chk("up_lo_forced2", d, 32'h0000_0010);
    rd(3'd4, d); chk("up_hi_forced2", d, 32'h1234_5678);
    release dut.r_uptime;

    // 3: first barrier round
    wr(3'd5, 32'h1); wr(3'd5, 32'h2); wr(3'd5, 32'h8);
    rd(3'd5, d); chk("bar_partial", d, 32'h0000_000B);
    @(negedge clock);
    bus.address = 3'd5; bus.writedata = 32'h4; bus.write = 1'b1;
    @(negedge clock);
    bus.write = 1'b0;
    chk("rel_before", {31'd0, barrier_release}, 32'h0);
    @(negedge clock);
    chk("rel_pulse", {31'd0, barrier_release}, 32'h1);
    @(negedge clock);
    chk("rel_after", {31'd0, barrier_release}, 32'h0);
    rd(3'd5, d); chk("bar_round1", d, 32'h0001_0000);

    // 4: write landing in the release cycle
    wr(3'd5, 32'h1); wr(3'd5, 32'h2); wr(3'd5, 32'h8);
    @(negedge clock);
    bus.address = 3'd5; bus.writedata = 32'h4; bus.write = 1'b1;
    @(negedge clock);
    bus.writedata = 32'h1;
    chk("rel2_before", {31'd0, barrier_release}, 32'h0);
    @(negedge clock);
    bus.write = 1'b0;
    chk("rel2_pulse", {31'd0, barrier_release}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rel2_no_second", {31'd0, barrier_release}, 32'h0);
    end
    rd(3'd5, d); chk("bar_carry", d, 32'h0002_0001);

    // 5: read in release cycle, then gen wrap with GEN_W=2
    @(negedge clock);
    bus.address = 3'd5; bus.writedata = 32'hE; bus.write = 1'b1;
    @(negedge clock);
    bus.write = 1'b0; bus.read = 1'b1;
    @(negedge clock);
    bus.read = 1'b0;
    chk("bar_read_release", bus.readdata, 32'h0002_000F);
    chk("rel3_pulse", {31'd0, barrier_release}, 32'h1);
    wr(3'd5, 32'hF);
    repeat (2) @(negedge clock);
    wr(3'd5, 32'h3); wr(3'd5, 32'hC);
    repeat (2) @(negedge clock);
    rd(3'd5, d); chk("gen_wrap", d, 32'h0001_0000);
    wr(3'd5, 32'hFFFF_FFF0);
    rd(3'd5, d); chk("bar_high_ignored", d, 32'h0001_0000);

    // 6: scratch, unmapped word, mid-operation reset
    wr(3'd6, 32'hDEAD_BEEF);
    rd(3'd6, d); chk("scratch", d, 32'hDEAD_BEEF);
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd7, d); chk("word7", d, 32'h0);
    wr(3'd5, 32'h1); wr(3'd5, 32'h2);
    rd(3'd5, d); chk("bar_pre_reset", d, 32'h0001_0003);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_readdata", bus.readdata, 32'h0);
    chk("async_rst_release", {31'd0, barrier_release}, 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    rd(3'd5, d); chk("rst_barrier", d, 32'h0);
    rd(3'd6, d); chk("rst_scratch", d, 32'h0);
    rd(3'd4, d); chk("rst_hi_shadow", d, 32'h0);
    rd(3'd7, d); chk("rst_word7", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
